// File: rtl/rocketcpu_pkg.sv
// -----------------------------------------------------------------------------
// rocketcpu_pkg
// Shared definitions for the RocketCPU SoC bus fabric.
//   - Default memory map (base/mask pairs). A slave window matches an address
//     when (adr & MASK) == BASE.
//   - Packed default window vectors for the 8-slave interconnect, with slave 0
//     in the least significant 32 bits.
//   - Interconnect grant-state encoding and the read data returned on an
//     error ack.
// No ports: package only.
// -----------------------------------------------------------------------------
package rocketcpu_pkg;

    // Default memory map
    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK    = 32'hFFFF_8000;
    localparam logic [31:0] FLASH_BASE  = 32'h0100_0000;
    localparam logic [31:0] FLASH_MASK  = 32'hFF00_0000;
    localparam logic [31:0] GPIO_BASE   = 32'h0200_0000;
    localparam logic [31:0] GPIO_MASK   = 32'hFFFF_F000;
    localparam logic [31:0] UART_BASE   = 32'h0400_0000;
    localparam logic [31:0] UART_MASK   = 32'hFFFF_F000;
    localparam logic [31:0] CODEC_BASE  = 32'h0400_1000;
    localparam logic [31:0] CODEC_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] TIMER0_BASE = 32'h0400_2000;
    localparam logic [31:0] TIMER0_MASK = 32'hFFFF_F000;
    localparam logic [31:0] TIMER1_BASE = 32'h0400_3000;
    localparam logic [31:0] TIMER1_MASK = 32'hFFFF_F000;
    localparam logic [31:0] IRQ_BASE    = 32'h0400_4000;
    localparam logic [31:0] IRQ_MASK    = 32'hFFFF_F000;
    // AUDIO sits outside the default 8-window map; SoC variants that need it
    // instantiate the interconnect with NSLAVES=9 and append this window.
    localparam logic [31:0] AUDIO_BASE  = 32'h0500_0000;
    localparam logic [31:0] AUDIO_MASK  = 32'hFFFF_0000;

    localparam int DEF_NSLAVES = 8;

    // Slave index order: 0 RAM, 1 FLASH, 2 GPIO, 3 UART, 4 CODEC,
    // 5 TIMER0, 6 TIMER1, 7 IRQ.
    localparam logic [DEF_NSLAVES*32-1:0] DEF_SLV_BASE = {
        IRQ_BASE, TIMER1_BASE, TIMER0_BASE, CODEC_BASE,
        UART_BASE, GPIO_BASE, FLASH_BASE, RAM_BASE
    };
    localparam logic [DEF_NSLAVES*32-1:0] DEF_SLV_MASK = {
        IRQ_MASK, TIMER1_MASK, TIMER0_MASK, CODEC_MASK,
        UART_MASK, GPIO_MASK, FLASH_MASK, RAM_MASK
    };

    // GPIO has no ack output of its own.
    localparam logic [DEF_NSLAVES-1:0] DEF_SLV_AUTOACK = 8'b0000_0100;

    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } wb_state_e;

endpackage

// File: rtl/rocketcpu_wb_decode.sv
// -----------------------------------------------------------------------------
// rocketcpu_wb_decode
// Combinational address decoder. Compares the address against NSLAVES
// base/mask windows and reports the lowest-index matching window as a
// one-hot vector.
// Ports:
//   i_adr   in  32       address to decode
//   o_hit   out NSLAVES  one-hot hit vector (all zero when nothing matches)
//   o_none  out 1        no window matched
// -----------------------------------------------------------------------------
module rocketcpu_wb_decode
    import rocketcpu_pkg::*;
#(
    parameter int                    NSLAVES  = DEF_NSLAVES,
    parameter logic [NSLAVES*32-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NSLAVES*32-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input  logic [31:0]        i_adr,
    output logic [NSLAVES-1:0] o_hit,
    output logic               o_none
);

    // Overlapping windows resolve to the lowest index, so the first match
    // found while walking upwards is the only bit set.
    always_comb begin
        o_hit = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if ((o_hit == '0) &&
                ((i_adr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                o_hit[i] = 1'b1;
            end
        end
    end

    assign o_none = (o_hit == '0);

endmodule

// File: rtl/rocketcpu_wb_interconnect.sv
// -----------------------------------------------------------------------------
// rocketcpu_wb_interconnect
// Wishbone-classic interconnect for the SERV core. Arbitrates the instruction
// and data masters (dbus has fixed priority) onto one shared slave bus,
// decodes the address into a one-hot slave select, generates acks for slaves
// without an ack output, and terminates unmapped or hung accesses with an
// error ack carrying ERR_DATA.
// Ports:
//   i_wb_clk               in   1          clock
//   reset                  in   1          synchronous active-high reset
//   i_ibus_adr/i_ibus_cyc  in   32/1       instruction master request
//   o_ibus_rdt/o_ibus_ack  out  32/1       instruction master response
//   i_dbus_adr/dat/sel/we/cyc in 32/32/4/1/1 data master request
//   o_dbus_rdt/o_dbus_ack  out  32/1       data master response
//   o_s_adr/dat/sel/we     out  32/32/4/1  shared slave request (registered)
//   o_s_cyc                out  NSLAVES    one-hot slave select (registered)
//   i_s_rdt                in   NSLAVES*32 packed slave read data
//   i_s_ack                in   NSLAVES    slave acks
//   o_err                  out  1          high during any error ack
//   o_err_adr              out  32         address of the last errored access
// -----------------------------------------------------------------------------
module rocketcpu_wb_interconnect
    import rocketcpu_pkg::*;
#(
    parameter int                    NSLAVES     = DEF_NSLAVES,
    parameter logic [NSLAVES*32-1:0] SLV_BASE    = DEF_SLV_BASE,
    parameter logic [NSLAVES*32-1:0] SLV_MASK    = DEF_SLV_MASK,
    parameter logic [NSLAVES-1:0]    SLV_AUTOACK = DEF_SLV_AUTOACK,
    parameter int                    TIMEOUT     = 255,
    parameter logic [31:0]           ERR_DATA    = DEF_ERR_DATA
) (
    input  logic                    i_wb_clk,
    input  logic                    reset,
    input  logic [31:0]             i_ibus_adr,
    input  logic                    i_ibus_cyc,
    output logic [31:0]             o_ibus_rdt,
    output logic                    o_ibus_ack,
    input  logic [31:0]             i_dbus_adr,
    input  logic [31:0]             i_dbus_dat,
    input  logic [3:0]              i_dbus_sel,
    input  logic                    i_dbus_we,
    input  logic                    i_dbus_cyc,
    output logic [31:0]             o_dbus_rdt,
    output logic                    o_dbus_ack,
    output logic [31:0]             o_s_adr,
    output logic [31:0]             o_s_dat,
    output logic [3:0]              o_s_sel,
    output logic                    o_s_we,
    output logic [NSLAVES-1:0]      o_s_cyc,
    input  logic [NSLAVES*32-1:0]   i_s_rdt,
    input  logic [NSLAVES-1:0]      i_s_ack,
    output logic                    o_err,
    output logic [31:0]             o_err_adr
);

    // A zero TIMEOUT disables the watchdog; keep a 1-bit counter so the
    // declaration stays legal.
    localparam int                CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    wb_state_e           r_state;
    logic [NSLAVES-1:0]  r_s_cyc;
    logic                r_none;
    logic [CNT_W-1:0]    r_cnt;
    logic [31:0]         r_s_adr;
    logic [31:0]         r_s_dat;
    logic [3:0]          r_s_sel;
    logic                r_s_we;
    logic [31:0]         r_err_adr;

    logic [31:0]         w_req_adr;
    logic [NSLAVES-1:0]  w_hit;
    logic                w_none;
    logic                w_m_cyc;
    logic                w_slv_ack;
    logic                w_tmo;
    logic                w_err_ack;
    logic                w_ack;
    logic [31:0]         w_slv_rdt;
    logic [31:0]         w_m_rdt;

    // Decode the address of whichever master will win the grant this cycle.
    assign w_req_adr = i_dbus_cyc ? i_dbus_adr : i_ibus_adr;

    rocketcpu_wb_decode #(
        .NSLAVES  (NSLAVES),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .i_adr  (w_req_adr),
        .o_hit  (w_hit),
        .o_none (w_none)
    );

    always_comb begin
        w_m_cyc = 1'b0;
        case (r_state)
            GNT_I:   w_m_cyc = i_ibus_cyc;
            GNT_D:   w_m_cyc = i_dbus_cyc;
            default: w_m_cyc = 1'b0;
        endcase
    end

    // Auto-ack slaves look permanently ready, so their own ack bit is moot.
    assign w_slv_ack = |(r_s_cyc & (i_s_ack | SLV_AUTOACK));
    assign w_tmo     = (TIMEOUT != 0) && (r_cnt == TO_VAL);
    // A real ack in the expiry cycle beats the watchdog.
    assign w_err_ack = w_m_cyc && !w_slv_ack && (r_none || w_tmo);
    assign w_ack     = w_m_cyc && (w_slv_ack || r_none || w_tmo);

    // Select is one-hot, so an AND-OR reduction is the whole mux.
    always_comb begin
        w_slv_rdt = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (r_s_cyc[i]) begin
                w_slv_rdt = w_slv_rdt | i_s_rdt[32*i +: 32];
            end
        end
    end

    assign w_m_rdt = w_err_ack ? ERR_DATA : w_slv_rdt;

    // Grant FSM and registered slave-side request
    always_ff @(posedge i_wb_clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_s_cyc   <= '0;
            r_none    <= 1'b0;
            r_cnt     <= '0;
            r_err_adr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (i_dbus_cyc) begin
                        r_state <= GNT_D;
                        r_s_cyc <= w_hit;
                        r_none  <= w_none;
                        r_s_adr <= i_dbus_adr;
                        r_s_dat <= i_dbus_dat;
                        r_s_sel <= i_dbus_sel;
                        r_s_we  <= i_dbus_we;
                    end else if (i_ibus_cyc) begin
                        r_state <= GNT_I;
                        r_s_cyc <= w_hit;
                        r_none  <= w_none;
                        r_s_adr <= i_ibus_adr;
                        r_s_dat <= '0;
                        r_s_sel <= 4'hF;
                        r_s_we  <= 1'b0;
                    end
                end
                GNT_I, GNT_D: begin
                    // Ack or abort both end the access on this edge.
                    if (!w_m_cyc || w_ack) begin
                        r_state <= IDLE;
                        r_s_cyc <= '0;
                        r_none  <= 1'b0;
                        r_cnt   <= '0;
                        if (w_err_ack) begin
                            r_err_adr <= r_s_adr;
                        end
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_s_cyc <= '0;
                    r_none  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_s_adr   = r_s_adr;
    assign o_s_dat   = r_s_dat;
    assign o_s_sel   = r_s_sel;
    assign o_s_we    = r_s_we;
    assign o_s_cyc   = r_s_cyc;
    assign o_err_adr = r_err_adr;

    // Responses are suppressed while reset is held so no ack leaks out of a
    // grant that reset is about to cancel.
    assign o_dbus_ack = !reset && (r_state == GNT_D) && w_ack;
    assign o_ibus_ack = !reset && (r_state == GNT_I) && w_ack;
    assign o_dbus_rdt = (!reset && (r_state == GNT_D)) ? w_m_rdt : '0;
    assign o_ibus_rdt = (!reset && (r_state == GNT_I)) ? w_m_rdt : '0;
    assign o_err      = !reset && w_err_ack;

endmodule

// File: tb/tb_rocketcpu_wb_interconnect.sv
`timescale 1ns/1ps
module tb_rocketcpu_wb_interconnect;
    import rocketcpu_pkg::*;

    localparam int          NS   = 8;
    localparam int          TMO  = 4;
    localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [31:0]       ibus_adr;
    logic              ibus_cyc;
    logic [31:0]       ibus_rdt;
    logic              ibus_ack;
    logic [31:0]       dbus_adr, dbus_dat;
    logic [3:0]        dbus_sel;
    logic              dbus_we, dbus_cyc;
    logic [31:0]       dbus_rdt;
    logic              dbus_ack;
    logic [31:0]       s_adr, s_dat;
    logic [3:0]        s_sel;
    logic              s_we;
    logic [NS-1:0]     s_cyc;
    logic [NS*32-1:0]  s_rdt;
    logic [NS-1:0]     s_ack;
    logic              err;
    logic [31:0]       err_adr;

    rocketcpu_wb_interconnect #(
        .NSLAVES(NS), .SLV_BASE(DEF_SLV_BASE), .SLV_MASK(DEF_SLV_MASK),
        .SLV_AUTOACK(DEF_SLV_AUTOACK), .TIMEOUT(TMO), .ERR_DATA(ERRV)
    ) dut (
        .i_wb_clk(clk), .reset(reset),
        .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc),
        .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
        .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel),
        .i_dbus_we(dbus_we), .i_dbus_cyc(dbus_cyc),
        .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
        .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we),
        .o_s_cyc(s_cyc), .i_s_rdt(s_rdt), .i_s_ack(s_ack),
        .o_err(err), .o_err_adr(err_adr)
    );

    // Slave models: slave i acks after lat[i] wait cycles of being selected.
    int          lat[NS];
    logic [31:0] sdat[NS];
    int          wcnt[NS];

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) wcnt[i] <= s_cyc[i] ? wcnt[i] + 1 : 0;
    end

    always_comb begin
        s_ack = '0;
        s_rdt = '0;
        for (int i = 0; i < NS; i++) begin
            s_ack[i]          = s_cyc[i] && (wcnt[i] == lat[i]);
            s_rdt[32*i +: 32] = sdat[i];
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Observations of the last access
    int          r_kd, r_ki, r_stray;
    logic [31:0] r_rdtd, r_rdti, r_adr1, r_dat1;
    logic        r_errd, r_erri, r_we1;
    logic [3:0]  r_sel1;
    logic [NS-1:0] r_scyc1;

    // Reference model: lowest-index window match, -1 if none.
    function automatic int ref_slave(input logic [31:0] adr);
        for (int i = 0; i < NS; i++)
            if ((adr & DEF_SLV_MASK[32*i +: 32]) == DEF_SLV_BASE[32*i +: 32]) return i;
        return -1;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge in an idle cycle.
    task automatic run(input bit rq_d, input logic [31:0] d_adr, input logic [31:0] d_dat,
                       input logic [3:0] d_sel, input logic d_we,
                       input bit rq_i, input logic [31:0] i_adr);
        bit pend_d, pend_i, drop_d, drop_i;
        pend_d = rq_d; pend_i = rq_i;
        r_kd = -1; r_ki = -1; r_stray = 0;
        r_rdtd = '0; r_rdti = '0; r_errd = 1'b0; r_erri = 1'b0;
        dbus_adr = d_adr; dbus_dat = d_dat; dbus_sel = d_sel; dbus_we = d_we;
        dbus_cyc = rq_d;
        ibus_adr = i_adr; ibus_cyc = rq_i;
        for (int k = 1; k <= 60 && (pend_d || pend_i); k++) begin
            @(negedge clk);
            drop_d = 1'b0; drop_i = 1'b0;
            if (k == 1) begin
                r_scyc1 = s_cyc; r_we1 = s_we; r_sel1 = s_sel; r_adr1 = s_adr; r_dat1 = s_dat;
            end
            if (err && !(dbus_ack || ibus_ack)) r_stray++;
            if (dbus_ack) begin
                if (!pend_d) r_stray++;
                else begin r_kd = k; r_rdtd = dbus_rdt; r_errd = err; pend_d = 1'b0; drop_d = 1'b1; end
            end
            if (ibus_ack) begin
                if (!pend_i) r_stray++;
                else begin r_ki = k; r_rdti = ibus_rdt; r_erri = err; pend_i = 1'b0; drop_i = 1'b1; end
            end
            @(posedge clk); #1;
            if (drop_d) dbus_cyc = 1'b0;
            if (drop_i) ibus_cyc = 1'b0;
        end
        if (pend_d || pend_i) begin
            n_cmp++; n_fail++;
            $display("FAIL run_ack_bound: no ack within 60 cycles (pending d=%0d i=%0d)", pend_d, pend_i);
        end
        dbus_cyc = 1'b0; ibus_cyc = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (s_cyc !== '0)     begin n_fail++; $display("FAIL rst_s_cyc: got %h want 0", s_cyc); end
        n_cmp++; if (dbus_ack !== 1'b0) begin n_fail++; $display("FAIL rst_dbus_ack: got %b want 0", dbus_ack); end
        n_cmp++; if (ibus_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ibus_ack: got %b want 0", ibus_ack); end
        n_cmp++; if (dbus_rdt !== '0)  begin n_fail++; $display("FAIL rst_dbus_rdt: got %h want 0", dbus_rdt); end
        n_cmp++; if (ibus_rdt !== '0)  begin n_fail++; $display("FAIL rst_ibus_rdt: got %h want 0", ibus_rdt); end
        n_cmp++; if (err !== 1'b0)     begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
        n_cmp++; if (err_adr !== '0)   begin n_fail++; $display("FAIL rst_err_adr: got %h want 0", err_adr); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ram_read();
        lat[0] = 2; sdat[0] = 32'h1234_5678;
        run(1'b1, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (r_scyc1 !== 8'h01)   begin n_fail++; $display("FAIL ram_s_cyc: got %h want 01", r_scyc1); end
        n_cmp++; if (r_kd !== 3)          begin n_fail++; $display("FAIL ram_ack_cycle: got %0d want 3", r_kd); end
        n_cmp++; if (r_rdtd !== sdat[0])  begin n_fail++; $display("FAIL ram_rdt: got %h want %h", r_rdtd, sdat[0]); end
        n_cmp++; if (r_errd !== 1'b0)     begin n_fail++; $display("FAIL ram_err: got %b want 0", r_errd); end
        n_cmp++; if (r_stray !== 0)       begin n_fail++; $display("FAIL ram_stray_ack: got %0d want 0", r_stray); end
    endtask

    task automatic test_priority();
        lat[0] = 1; lat[1] = 0; sdat[0] = 32'h0BAD_F00D; sdat[1] = 32'hCAFE_0001;
        run(1'b1, 32'h0000_0100, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0100_0040);
        n_cmp++; if (r_scyc1 !== 8'h01)  begin n_fail++; $display("FAIL prio_first_grant: got %h want 01", r_scyc1); end
        n_cmp++; if (r_kd !== 2)         begin n_fail++; $display("FAIL prio_dbus_cycle: got %0d want 2", r_kd); end
        n_cmp++; if (r_ki !== 4)         begin n_fail++; $display("FAIL prio_ibus_cycle: got %0d want 4", r_ki); end
        n_cmp++; if (r_rdtd !== sdat[0]) begin n_fail++; $display("FAIL prio_dbus_rdt: got %h want %h", r_rdtd, sdat[0]); end
        n_cmp++; if (r_rdti !== sdat[1]) begin n_fail++; $display("FAIL prio_ibus_rdt: got %h want %h", r_rdti, sdat[1]); end
        n_cmp++; if (r_stray !== 0)      begin n_fail++; $display("FAIL prio_stray_ack: got %0d want 0", r_stray); end
    endtask

    task automatic test_autoack();
        lat[2] = 1000; sdat[2] = 32'h6000_0002;
        run(1'b1, 32'h0200_0010, 32'hA5A5_0F0F, 4'b0011, 1'b1, 1'b0, 32'h0);
        n_cmp++; if (r_scyc1 !== 8'h04)       begin n_fail++; $display("FAIL auto_s_cyc: got %h want 04", r_scyc1); end
        n_cmp++; if (r_we1 !== 1'b1)          begin n_fail++; $display("FAIL auto_we: got %b want 1", r_we1); end
        n_cmp++; if (r_sel1 !== 4'b0011)      begin n_fail++; $display("FAIL auto_sel: got %h want 3", r_sel1); end
        n_cmp++; if (r_dat1 !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL auto_dat: got %h want a5a50f0f", r_dat1); end
        n_cmp++; if (r_kd !== 1)              begin n_fail++; $display("FAIL auto_ack_cycle: got %0d want 1", r_kd); end
        n_cmp++; if (r_rdtd !== sdat[2])      begin n_fail++; $display("FAIL auto_rdt: got %h want %h", r_rdtd, sdat[2]); end
        n_cmp++; if (r_errd !== 1'b0)         begin n_fail++; $display("FAIL auto_err: got %b want 0", r_errd); end
    endtask

    task automatic test_unmapped();
        run(1'b1, 32'h0300_0000, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (r_scyc1 !== '0)        begin n_fail++; $display("FAIL unm_s_cyc: got %h want 0", r_scyc1); end
        n_cmp++; if (r_kd !== 1)            begin n_fail++; $display("FAIL unm_ack_cycle: got %0d want 1", r_kd); end
        n_cmp++; if (r_rdtd !== ERRV)       begin n_fail++; $display("FAIL unm_rdt: got %h want %h", r_rdtd, ERRV); end
        n_cmp++; if (r_errd !== 1'b1)       begin n_fail++; $display("FAIL unm_err: got %b want 1", r_errd); end
        n_cmp++; if (err_adr !== 32'h0300_0000) begin n_fail++; $display("FAIL unm_err_adr: got %h want 03000000", err_adr); end
        n_cmp++; if (r_stray !== 0)         begin n_fail++; $display("FAIL unm_stray: got %0d want 0", r_stray); end
    endtask

    task automatic test_timeout();
        lat[1] = 1000;
        run(1'b1, 32'h0100_0200, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (r_kd !== TMO + 1)      begin n_fail++; $display("FAIL tmo_ack_cycle: got %0d want %0d", r_kd, TMO + 1); end
        n_cmp++; if (r_rdtd !== ERRV)       begin n_fail++; $display("FAIL tmo_rdt: got %h want %h", r_rdtd, ERRV); end
        n_cmp++; if (r_errd !== 1'b1)       begin n_fail++; $display("FAIL tmo_err: got %b want 1", r_errd); end
        n_cmp++; if (err_adr !== 32'h0100_0200) begin n_fail++; $display("FAIL tmo_err_adr: got %h want 01000200", err_adr); end
        lat[1] = TMO; sdat[1] = 32'h7777_1111;
        run(1'b1, 32'h0100_0300, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (r_kd !== TMO + 1)      begin n_fail++; $display("FAIL tie_ack_cycle: got %0d want %0d", r_kd, TMO + 1); end
        n_cmp++; if (r_rdtd !== sdat[1])    begin n_fail++; $display("FAIL tie_rdt: got %h want %h", r_rdtd, sdat[1]); end
        n_cmp++; if (r_errd !== 1'b0)       begin n_fail++; $display("FAIL tie_err: got %b want 0", r_errd); end
        n_cmp++; if (err_adr !== 32'h0100_0200) begin n_fail++; $display("FAIL tie_err_adr: got %h want 01000200", err_adr); end
    endtask

    task automatic test_reset_mid();
        lat[3] = 1000;
        dbus_adr = 32'h0400_0008; dbus_we = 1'b0; dbus_sel = 4'hF; dbus_cyc = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (s_cyc !== 8'h08) begin n_fail++; $display("FAIL rmid_wait_s_cyc: got %h want 08", s_cyc); end
        reset = 1'b1;
        #1;
        n_cmp++; if (dbus_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_ack_in_reset: got %b want 0", dbus_ack); end
        @(negedge clk);
        n_cmp++; if (s_cyc !== '0)      begin n_fail++; $display("FAIL rmid_s_cyc: got %h want 0", s_cyc); end
        n_cmp++; if (dbus_ack !== 1'b0 || ibus_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_acks: got d=%b i=%b want 0", dbus_ack, ibus_ack); end
        n_cmp++; if (err_adr !== '0)    begin n_fail++; $display("FAIL rmid_err_adr: got %h want 0", err_adr); end
        reset = 1'b0; dbus_cyc = 1'b0;
        @(negedge clk);
        lat[0] = 0; sdat[0] = 32'h5151_A0A0;
        run(1'b1, 32'h0000_0040, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (r_kd !== 1)         begin n_fail++; $display("FAIL rmid_after_cycle: got %0d want 1", r_kd); end
        n_cmp++; if (r_rdtd !== sdat[0]) begin n_fail++; $display("FAIL rmid_after_rdt: got %h want %h", r_rdtd, sdat[0]); end
    endtask

    task automatic test_random();
        int s, es, ek, l;
        bit use_d, eerr;
        logic [31:0] adr, dat, erdt, last_err;
        logic [3:0] sel;
        logic we;
        logic [NS-1:0] ecyc;
        last_err = 32'h0;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NS; i++) sdat[i] = $urandom;
            s = $urandom_range(0, 8);
            use_d = $urandom_range(0, 1);
            if (s == 8) adr = 32'h0300_0000 | ($urandom & 32'h00FF_FFFC);
            else adr = DEF_SLV_BASE[32*s +: 32] | ($urandom & ~DEF_SLV_MASK[32*s +: 32] & 32'hFFFF_FFFC);
            l = $urandom_range(0, 6);
            if (s < 8) lat[s] = l;
            dat = $urandom; sel = 4'($urandom); we = 1'($urandom);
            // Expected result from the address map and response rules
            es = ref_slave(adr);
            ecyc = '0;
            if (es < 0) begin ek = 1; eerr = 1'b1; erdt = ERRV; end
            else begin
                ecyc[es] = 1'b1;
                if (DEF_SLV_AUTOACK[es]) begin ek = 1; eerr = 1'b0; erdt = sdat[es]; end
                else if (lat[es] <= TMO) begin ek = lat[es] + 1; eerr = 1'b0; erdt = sdat[es]; end
                else begin ek = TMO + 1; eerr = 1'b1; erdt = ERRV; end
            end
            if (eerr) last_err = adr;
            if (use_d) begin
                run(1'b1, adr, dat, sel, we, 1'b0, 32'h0);
                n_cmp++; if (r_kd !== ek || r_rdtd !== erdt || r_errd !== eerr)
                    begin n_fail++; $display("FAIL rnd_dbus[%0d]: adr %h got k=%0d rdt=%h err=%b want k=%0d rdt=%h err=%b", t, adr, r_kd, r_rdtd, r_errd, ek, erdt, eerr); end
                n_cmp++; if (r_we1 !== we || r_sel1 !== sel || r_dat1 !== dat)
                    begin n_fail++; $display("FAIL rnd_dbus_req[%0d]: got we=%b sel=%h dat=%h want we=%b sel=%h dat=%h", t, r_we1, r_sel1, r_dat1, we, sel, dat); end
            end else begin
                run(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, adr);
                n_cmp++; if (r_ki !== ek || r_rdti !== erdt || r_erri !== eerr)
                    begin n_fail++; $display("FAIL rnd_ibus[%0d]: adr %h got k=%0d rdt=%h err=%b want k=%0d rdt=%h err=%b", t, adr, r_ki, r_rdti, r_erri, ek, erdt, eerr); end
                n_cmp++; if (r_we1 !== 1'b0 || r_sel1 !== 4'hF)
                    begin n_fail++; $display("FAIL rnd_ibus_req[%0d]: got we=%b sel=%h want we=0 sel=f", t, r_we1, r_sel1); end
            end
            n_cmp++; if (r_scyc1 !== ecyc || r_adr1 !== adr)
                begin n_fail++; $display("FAIL rnd_select[%0d]: got cyc=%h adr=%h want cyc=%h adr=%h", t, r_scyc1, r_adr1, ecyc, adr); end
            n_cmp++; if (err_adr !== last_err || r_stray !== 0)
                begin n_fail++; $display("FAIL rnd_err_adr[%0d]: got %h stray=%0d want %h stray=0", t, err_adr, r_stray, last_err); end
        end
    endtask

    initial begin
        reset = 1'b1;
        ibus_adr = '0; ibus_cyc = 1'b0;
        dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
        for (int i = 0; i < NS; i++) begin lat[i] = 0; sdat[i] = 32'h0; end
        @(negedge clk);
        test_reset();
        test_ram_read();
        test_priority();
        test_autoack();
        test_unmapped();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rocketcpu_wb_interconnect.md
# rocketcpu_wb_interconnect

Parametrised Wishbone-classic interconnect that replaces the hand-written bus glue in the SoC top. It arbitrates the SERV instruction and data buses onto one shared slave bus and decodes the address against NSLAVES base/mask windows. It also generates acks for slaves that have no ack output, and it terminates unmapped or hung accesses with an error ack so the CPU can never stall forever.

## Interface
- NSLAVES, 8: number of slave windows.
- SLV_BASE, packed NSLAVES×32: window base addresses; slave i uses bits [32i+31:32i].
- SLV_MASK, packed NSLAVES×32: window masks; slave i matches when (adr & MASK_i) == BASE_i.
- SLV_AUTOACK, NSLAVES bits: a 1 means the interconnect generates that slave's ack and ignores its i_s_ack bit.
- TIMEOUT, 255: number of granted cycles without an ack before a forced error ack; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on an error ack.

Ports:
- i_wb_clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_ibus_adr  in  32  instruction fetch address
- i_ibus_cyc  in  1  instruction request
- o_ibus_rdt  out  32  instruction read data
- o_ibus_ack  out  1  instruction ack
- i_dbus_adr / i_dbus_dat / i_dbus_sel / i_dbus_we / i_dbus_cyc  in  32/32/4/1/1  data master request
- o_dbus_rdt  out  32  data read data
- o_dbus_ack  out  1  data ack
- o_s_adr / o_s_dat / o_s_sel / o_s_we  out  32/32/4/1  shared slave request
- o_s_cyc  out  NSLAVES  one-hot slave select
- i_s_rdt  in  NSLAVES×32  packed slave read data
- i_s_ack  in  NSLAVES  slave acks
- o_err  out  1  one-cycle pulse on any error ack
- o_err_adr  out  32  address of the last errored access

## Operation
- State machine with three states: IDLE, GNT_I, GNT_D.
- IDLE:
  - If i_dbus_cyc is high, go to GNT_D. Dbus has fixed priority.
  - Otherwise, if i_ibus_cyc is high, go to GNT_I.
- Granted states:
  - o_s_adr/dat/sel/we are driven from the granted master. Ibus forces we=0 and sel=4'hF.
  - Decode picks the lowest-index matching window and asserts the corresponding o_s_cyc bit.
  - The ack and rdt from the selected slave pass combinationally to the granted master only. The other master sees ack=0 and rdt=0.
- AUTOACK slave: ack is asserted in the first granted cycle, and rdt is taken from i_s_rdt for that slave.
- No window matches: o_s_cyc stays all-zero. Error ack in the first granted cycle, rdt=ERR_DATA, o_err=1, o_err_adr latched.
- Timeout:
  - The counter clears on grant and counts each granted cycle without an ack.
  - When count==TIMEOUT, an error ack is forced in that cycle with the same outputs as the unmapped case, and o_err_adr is latched.
- Any ack (slave, auto or error) returns the state to IDLE on the same edge. A new grant needs one IDLE cycle.
- Master drops cyc while granted (abort): return to IDLE, no ack, counter cleared.
- Simultaneous slave ack and timeout expiry: the slave ack wins, so no error is reported.
- Reset values: state IDLE, o_s_cyc=0, all acks 0, rdt 0, o_err=0, o_err_adr=0, counter 0.
- Reset mid-access drops o_s_cyc and acks in the next cycle. No ack is delivered during reset.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- Request seen at edge n: o_s_cyc is high from cycle n+1.
- Earliest ack (auto, unmapped or zero-wait slave) is in cycle n+1.
- Back-to-back accesses from the same master: at least 2 cycles per access.
- Slave-side outputs are registered from the grant state. Ack/rdt from slave to master is combinational, with one mux level.
- o_err is high for exactly the ack cycle.

## Structure
- Shared package rocketcpu_pkg holds:
  - default memory-map localparams: RAM 0x0000_0000/mask 0xFFFF_8000, FLASH, GPIO, UART, CODEC, TIMER0/1, IRQ, AUDIO;
  - the state encoding;
  - ERR_DATA.
- Sub-module rocketcpu_wb_decode: combinational, parametrised by NSLAVES, SLV_BASE and SLV_MASK. It takes adr and returns a one-hot hit vector and a "none" flag.

## Test plan
- Dbus read of 0x0000_0010 (RAM window, slave 0 acks after 2 cycles): o_s_cyc=0x01 from n+1, ack at n+3, rdt equals slave data, ibus ack stays 0.
- ibus_cyc and dbus_cyc both rise at the same edge: dbus is served first. Ibus is granted after one IDLE cycle and gets its ack with the correct rdt.
- Dbus write to 0x0200_0000 (AUTOACK GPIO): o_s_we=1, ack at n+1, i_s_ack for that slave ignored.
- Read of unmapped 0x0300_0000: o_s_cyc=0, ack at n+1, rdt=0xDEADBEEF, o_err pulse, o_err_adr=0x0300_0000.
- Mapped slave never acks, with TIMEOUT=4: error ack at n+5 with ERR_DATA. A second case has the slave ack on that same cycle: no error.
- reset asserted while GNT_D is waiting: o_s_cyc=0 and all acks 0 on the next cycle, then a normal access completes after reset is released.
